tt_rr_arbiter: RTL and testbench
================================

# tt_rr_arbiter

Four-requester arbiter packaged as an 8-bit TinyTapeout user module. It shares one downstream resource between four requesters driven on `io_in`. It grants one requester at a time, with round-robin or fixed priority, and a bounded tenure. Grant state is reported on `io_out` so a bench or external logic can sequence the shared datapath.

## Interface

Parameters:
- `MAX_TENURE`, default 8: the most consecutive grant cycles a holder may keep while others wait. Legal range is 2..15.

Ports:
- `io_in[0]` (input, 1): clock, rising edge.
- `io_in[1]` (input, 1): reset, asynchronous, active-low.
- `io_in[5:2]` (input, 4): `req[3:0]`, level requests.
- `io_in[6]` (input, 1): `lock`. Holder keeps the grant past `MAX_TENURE` while this is high.
- `io_in[7]` (input, 1): `mode`. 0 = round-robin; 1 = fixed priority, req0 highest.
- `io_out[3:0]` (output, 4): `gnt[3:0]`, one-hot or zero.
- `io_out[5:4]` (output, 2): `gnt_id`, index of the current holder. Holds the last holder when `gnt` is zero.
- `io_out[6]` (output, 1): `busy`, 1 in GRANT state.
- `io_out[7]` (output, 1): `preempt`, a 1-cycle pulse when a grant is revoked by tenure expiry.

## Operation

- FSM states: IDLE, GRANT, HANDOFF.
- IDLE:
  - If any `req` is set, pick a winner and go to GRANT.
  - Load `gnt`/`gnt_id` and clear the tenure counter.
- GRANT:
  - The tenure counter increments each cycle and saturates at `MAX_TENURE-1`.
  - Holder `req` low → HANDOFF. This is a release; no preempt.
  - Tenure counter == `MAX_TENURE-1`, any other `req` set, and `lock`=0 → HANDOFF with `preempt`=1 for that cycle.
  - Otherwise stay in GRANT. A lone requester holds indefinitely.
- HANDOFF:
  - `gnt`=0 for exactly one cycle (dead cycle).
  - Then arbitrate the same way as IDLE, or go to IDLE if no `req` is set.
- Arbitration:
  - Round-robin: search starts at `rr_ptr+1` mod 4 and ascends with wrap. `rr_ptr` updates to the winner on every grant.
  - Fixed: the lowest index wins. `rr_ptr` is still updated.
- `mode` is sampled only at arbitration. Changing it mid-grant has no effect until the next pick.
- Simultaneous release and tenure expiry: treat as a release, `preempt`=0.
- A preempted holder still requesting is eligible again, but round-robin ordering puts it last.

## Timing

- All outputs are registered.
- Reset (async, `io_in[1]`=0):
  - FSM = IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `preempt`=0.
  - `rr_ptr`=3, so req0 wins first, and the tenure counter is 0.
  - Reset mid-grant drops `gnt` immediately, without waiting for a clock edge.
- Request latency: `req` high before edge N, from IDLE, gives `gnt` high after edge N. That is 1 cycle.
- Release latency: holder `req` low before edge N gives `gnt`=0 after edge N. The next winner's `gnt` is high after edge N+1.
- Tenure:
  - The holder sees `gnt` for exactly `MAX_TENURE` cycles when contended.
  - `preempt` is high in the first HANDOFF cycle, aligned with `gnt` dropping.
- Two requesters never see `gnt` in the same cycle, and never in adjacent cycles.

## Structure

- Shared package `tt_arb_pkg`:
  - State enum {IDLE, GRANT, HANDOFF}.
  - `N_REQ`=4, `ID_W`=2.
  - Tenure counter width 4.
- Sub-module `tt_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[3:0]`, `start_id`, `mode`.
  - Outputs: `win_id`, `win_valid`.
- Top module: FSM, counter, `rr_ptr`, and output registers.

## Test plan

1. Reset then single request:
   - Stimulus: `rst_n`=0 for 2 cycles; `req`=0100 from edge 3.
   - Response: `gnt`=0100, `gnt_id`=2, `busy`=1 one cycle later. The grant holds for 20 cycles and `preempt` never fires.
2. Round-robin rotation:
   - Stimulus: `req`=1111, `mode`=0, `MAX_TENURE`=8.
   - Response: grants go 0,1,2,3,0. Each grant lasts 8 cycles with a 1-cycle gap, and `preempt` pulses on every handoff.
3. Fixed priority:
   - Stimulus: `mode`=1, `req`=1010.
   - Response: id 1 wins. After id 1 is preempted, id 1 wins again and id 3 is never granted while `req[1]`=1.
4. Lock and release:
   - Stimulus: grant id 0 with `req`=0011 and `lock`=1 for 20 cycles; then drop `req[0]` at the same time as `lock`=0.
   - Response: no preempt during the lock. After the release, 1 gap cycle, then `gnt`=0010 with `preempt`=0.
5. Release on the expiry cycle:
   - Stimulus: holder drops `req` exactly at tenure count 7 while others are waiting.
   - Response: `preempt`=0 and normal handoff.
6. Async reset mid-grant:
   - Stimulus: assert `rst_n`=0 between edges while `gnt`=0001.
   - Response: all outputs go to 0 immediately. After release with `req`=0001, the grant returns after 1 cycle.

Source files
------------

// File: rtl/tt_arb_pkg.sv
// Shared types and constants for the four-requester TinyTapeout arbiter.
package tt_arb_pkg;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int TEN_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/tt_rr_pick.sv
// Combinational picker: rotating priority from start_id, or fixed (req0 first) when mode=1.
module tt_rr_pick
  import tt_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start_id,
  input  logic             mode,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);
  logic [ID_W-1:0] idx;

  // Walk from the lowest priority up so the last hit is the winner.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = mode ? ID_W'(i) : start_id + ID_W'(i);
      if (req[idx]) begin
        win_id    = idx;
        win_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tt_rr_arbiter.sv
// Four-requester arbiter with round-robin/fixed priority, bounded tenure and a dead
// cycle between holders; all outputs registered on io_out.
module tt_rr_arbiter
  import tt_arb_pkg::*;
#(
  parameter int MAX_TENURE = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);

  logic             clk, rst_n, lock, mode;
  logic [N_REQ-1:0] req;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign req   = io_in[5:2];
  assign lock  = io_in[6];
  assign mode  = io_in[7];

  state_t           state, state_d;
  logic [TEN_W-1:0] ten, ten_d;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_d, gnt_id, gnt_id_d;
  logic [N_REQ-1:0] gnt, gnt_d;
  logic             busy, busy_d, preempt, preempt_d;
  logic [ID_W-1:0]  win_id;
  logic             win_valid, holder_req, rivals, expire;

  tt_rr_pick u_pick (
    .req       (req),
    .start_id  (rr_ptr + ID_W'(1)),
    .mode      (mode),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  assign holder_req = req[gnt_id];
  assign rivals     = |(req & ~onehot(gnt_id));
  assign expire     = (ten == TEN_LAST) && rivals && !lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, HANDOFF: state_d = win_valid ? GRANT : IDLE;
      GRANT:         if (!holder_req || expire) state_d = HANDOFF;
      default:       state_d = IDLE;
    endcase
  end

  // Next values for the output registers; a release takes precedence over expiry.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = gnt_id;
    busy_d    = 1'b0;
    preempt_d = 1'b0;
    ten_d     = ten;
    rr_ptr_d  = rr_ptr;
    case (state)
      IDLE, HANDOFF: begin
        if (win_valid) begin
          gnt_d    = onehot(win_id);
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          ten_d    = '0;
          rr_ptr_d = win_id;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          preempt_d = 1'b0;
        end else if (expire) begin
          preempt_d = 1'b1;
        end else begin
          gnt_d  = gnt;
          busy_d = 1'b1;
          ten_d  = (ten == TEN_LAST) ? ten : ten + TEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      preempt <= 1'b0;
      ten     <= '0;
      rr_ptr  <= ID_W'(N_REQ - 1);
    end else begin
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      preempt <= preempt_d;
      ten     <= ten_d;
      rr_ptr  <= rr_ptr_d;
    end
  end

  assign io_out = {preempt, busy, gnt_id, gnt};
endmodule

// File: tb/tb_tt_rr_arbiter.sv
// Directed, table-driven bench for tt_rr_arbiter with MAX_TENURE=8.
module tb_tt_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       lock = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] io_in, io_out;
  int checks = 0;
  int errors = 0;

  assign io_in = {mode, lock, req, rst_n, clk};

  tt_rr_arbiter #(.MAX_TENURE(8)) dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       lock;
    logic       mode;
    int         n;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  // io_out = {preempt, busy, gnt_id, gnt}
  function automatic logic [7:0] o(input logic p, input logic b, input logic [1:0] id,
                                   input logic [3:0] g);
    return {p, b, id, g};
  endfunction

  task automatic add(input logic r, input logic [3:0] q, input logic l, input logic m,
                     input int n, input logic [7:0] e, input string nm);
    vec_t v;
    v.rst_n = r; v.req = q; v.lock = l; v.mode = m; v.n = n; v.exp = e; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int cyc, input logic [7:0] exp);
    checks++;
    if (io_out !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d io_out got %b exp %b", nm, cyc, io_out, exp);
    end
  endtask

  task automatic run_table();
    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].n; k++) begin
        rst_n = vq[i].rst_n;
        req   = vq[i].req;
        lock  = vq[i].lock;
        mode  = vq[i].mode;
        @(posedge clk);
        #1;
        check(vq[i].name, k, vq[i].exp);
      end
    end
  endtask

  initial begin
    // 1: reset then a single requester holds with no preempt
    add(0, 4'b0000, 0, 0, 2,  o(0,0,2'd0,4'b0000), "reset");
    add(1, 4'b0100, 0, 0, 21, o(0,1,2'd2,4'b0100), "single_hold");
    add(1, 4'b0000, 0, 0, 1,  o(0,0,2'd2,4'b0000), "single_rel");
    add(1, 4'b0000, 0, 0, 1,  o(0,0,2'd2,4'b0000), "idle_keep_id");
    // 2: round-robin rotation after a fresh reset
    add(0, 4'b0000, 0, 0, 1,  o(0,0,2'd0,4'b0000), "reset2");
    add(1, 4'b1111, 0, 0, 8,  o(0,1,2'd0,4'b0001), "rr_g0");
    add(1, 4'b1111, 0, 0, 1,  o(1,0,2'd0,4'b0000), "rr_pre0");
    add(1, 4'b1111, 0, 0, 8,  o(0,1,2'd1,4'b0010), "rr_g1");
    add(1, 4'b1111, 0, 0, 1,  o(1,0,2'd1,4'b0000), "rr_pre1");
    add(1, 4'b1111, 0, 0, 8,  o(0,1,2'd2,4'b0100), "rr_g2");
    add(1, 4'b1111, 0, 0, 1,  o(1,0,2'd2,4'b0000), "rr_pre2");
    add(1, 4'b1111, 0, 0, 8,  o(0,1,2'd3,4'b1000), "rr_g3");
    add(1, 4'b1111, 0, 0, 1,  o(1,0,2'd3,4'b0000), "rr_pre3");
    add(1, 4'b1111, 0, 0, 8,  o(0,1,2'd0,4'b0001), "rr_g0b");
    add(1, 4'b0000, 0, 0, 1,  o(0,0,2'd0,4'b0000), "rr_rel");
    add(1, 4'b0000, 0, 0, 1,  o(0,0,2'd0,4'b0000), "rr_idle");
    // 3: fixed priority, id1 re-wins after preempt, id3 starves
    add(1, 4'b1010, 0, 1, 8,  o(0,1,2'd1,4'b0010), "fx_g1");
    add(1, 4'b1010, 0, 1, 1,  o(1,0,2'd1,4'b0000), "fx_pre1");
    add(1, 4'b1010, 0, 1, 8,  o(0,1,2'd1,4'b0010), "fx_g1b");
    add(1, 4'b1010, 0, 1, 1,  o(1,0,2'd1,4'b0000), "fx_pre1b");
    add(1, 4'b1010, 0, 1, 8,  o(0,1,2'd1,4'b0010), "fx_g1c");
    add(1, 4'b1000, 0, 1, 1,  o(0,0,2'd1,4'b0000), "fx_rel1");
    add(1, 4'b1000, 0, 1, 20, o(0,1,2'd3,4'b1000), "fx_lone3");
    add(1, 4'b0000, 0, 1, 2,  o(0,0,2'd3,4'b0000), "fx_idle");
    // 4: lock suppresses expiry; release together with lock drop
    add(1, 4'b0011, 1, 0, 20, o(0,1,2'd0,4'b0001), "lock_hold");
    add(1, 4'b0010, 0, 0, 1,  o(0,0,2'd0,4'b0000), "lock_rel");
    add(1, 4'b0010, 0, 0, 3,  o(0,1,2'd1,4'b0010), "lock_next");
    add(1, 4'b0000, 0, 0, 2,  o(0,0,2'd1,4'b0000), "lock_idle");
    // 5: release on the expiry cycle is a plain release
    add(1, 4'b0101, 0, 0, 8,  o(0,1,2'd2,4'b0100), "exp_g2");
    add(1, 4'b0001, 0, 0, 1,  o(0,0,2'd2,4'b0000), "exp_rel");
    add(1, 4'b0001, 0, 0, 3,  o(0,1,2'd0,4'b0001), "exp_next");
    run_table();

    // 6: async reset between edges drops outputs at once
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold", 0, 8'h00);
    vq.delete();
    add(1, 4'b0001, 0, 0, 3,  o(0,1,2'd0,4'b0001), "post_rst_g0");
    add(1, 4'b0000, 0, 0, 1,  o(0,0,2'd0,4'b0000), "post_rst_rel");
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
